// File: rtl/vending_mealy_param.sv
// vending_mealy_param: 5/10/25 coin vending FSM with Mealy dispense and chg5 change/refund pulse train.
module vending_mealy_param #(
    parameter int PRICE    = 20,
    parameter int CREDIT_W = 6,
    parameter int EN_Q25   = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [1:0]          coin,
    input  logic                cancel,
    output logic                dispense,
    output logic                chg5,
    output logic                coin_reject,
    output logic                busy,
    output logic [CREDIT_W+2:0] credit
);
    localparam logic [CREDIT_W-1:0] P5 = CREDIT_W'(PRICE / 5);
    typedef enum logic {ACCEPT, PAYOUT} state_t;
    state_t state_q, state_d;
    logic [CREDIT_W-1:0] credit_q, credit_d, payout_q, payout_d, v, sum, chg;
    always_comb begin
        v = coin == 2'b01 ? CREDIT_W'(1) :
            coin == 2'b10 ? CREDIT_W'(2) :
            (coin == 2'b11 && EN_Q25 != 0) ? CREDIT_W'(5) : '0;
        sum = credit_q + v;
        chg = sum - P5;
        credit_d = credit_q;
        payout_d = payout_q;
        dispense = 1'b0;
        chg5 = 1'b0;
        coin_reject = 1'b0;
        if (rst) begin
            credit_d = '0;
            payout_d = '0;
        end else if (state_q == PAYOUT) begin
            chg5 = 1'b1;
            coin_reject = coin != 2'b00;
            payout_d = payout_q - 1'b1;
        end else if (cancel) begin
            coin_reject = coin != 2'b00;
            if (credit_q != '0) begin
                chg5 = 1'b1;
                payout_d = credit_q - 1'b1;
                credit_d = '0;
            end
        end else if (coin != 2'b00 && v == '0) begin
            coin_reject = 1'b1;
        end else if (sum >= P5) begin
            // credit stays below P5 between coins, so this only fires on a real coin
            dispense = 1'b1;
            chg5 = chg != '0;
            payout_d = chg != '0 ? chg - 1'b1 : '0;
            credit_d = '0;
        end else begin
            credit_d = sum;
        end
        state_d = payout_d != '0 ? PAYOUT : ACCEPT;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ACCEPT;
            credit_q <= '0;
            payout_q <= '0;
        end else begin
            state_q <= state_d;
            credit_q <= credit_d;
            payout_q <= payout_d;
        end
    end
    assign busy = state_q == PAYOUT;
    assign credit = {1'b0, credit_q, 2'b00} + (CREDIT_W+3)'(credit_q);
endmodule

// File: tb/tb_vending_mealy_param.sv
// tb_vending_mealy_param: money-unit model of the vending rules checked every cycle against
// an EN_Q25=1 and an EN_Q25=0 instance, plus literal pins on chosen cycles.
module tb_vending_mealy_param;
    localparam int PRICE = 20;
    logic clk = 1'b0, rst = 1'b1, cancel = 1'b0;
    logic [1:0] coin = 2'b00;
    logic [1:0] disp, chg, rej, bsy;
    logic [8:0] cr0, cr1;
    int tests = 0, fails = 0;
    logic armed = 1'b0;
    int m_cr [2] = '{0, 0};
    int m_ow [2] = '{0, 0};
    int n_cr [2] = '{0, 0};
    int n_ow [2] = '{0, 0};
    logic pin_on = 1'b0;
    string pin_nm = "";
    logic [3:0] pin_e = 4'b0;
    int pin_cr = 0, pin_sel = 0;

    vending_mealy_param #(.PRICE(PRICE), .CREDIT_W(6), .EN_Q25(1)) dut (
        .clk(clk), .rst(rst), .coin(coin), .cancel(cancel), .dispense(disp[0]),
        .chg5(chg[0]), .coin_reject(rej[0]), .busy(bsy[0]), .credit(cr0));
    vending_mealy_param #(.PRICE(PRICE), .CREDIT_W(6), .EN_Q25(0)) dut0 (
        .clk(clk), .rst(rst), .coin(coin), .cancel(cancel), .dispense(disp[1]),
        .chg5(chg[1]), .coin_reject(rej[1]), .busy(bsy[1]), .credit(cr1));

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int got, input int exp);
        tests++;
        if (got != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, got, exp, $time);
        end
    endtask

    // m_ow holds money still to be paid back after the current cycle
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            int val, tot;
            int ed, ec, er;
            ed = 0; ec = 0; er = 0;
            n_cr[i] = m_cr[i];
            n_ow[i] = m_ow[i];
            val = coin == 2'b01 ? 5 : coin == 2'b10 ? 10 : (coin == 2'b11 && i == 0) ? 25 : 0;
            tot = m_cr[i] + val;
            if (rst) begin
                n_cr[i] = 0;
                n_ow[i] = 0;
            end else if (m_ow[i] > 0) begin
                ec = 1;
                er = int'(coin != 2'b00);
                n_ow[i] = m_ow[i] - 5;
            end else if (cancel) begin
                er = int'(coin != 2'b00);
                if (m_cr[i] > 0) begin
                    ec = 1;
                    n_ow[i] = m_cr[i] - 5;
                    n_cr[i] = 0;
                end
            end else if (coin != 2'b00 && val == 0) begin
                er = 1;
            end else if (tot >= PRICE) begin
                ed = 1;
                ec = int'(tot > PRICE);
                n_ow[i] = tot > PRICE ? tot - PRICE - 5 : 0;
                n_cr[i] = 0;
            end else begin
                n_cr[i] = tot;
            end
            if (armed) begin
                chk($sformatf("model%0d dispense", i), int'(disp[i]), ed);
                chk($sformatf("model%0d chg5", i), int'(chg[i]), ec);
                chk($sformatf("model%0d coin_reject", i), int'(rej[i]), er);
                chk($sformatf("model%0d busy", i), int'(bsy[i]), int'(m_ow[i] > 0));
                chk($sformatf("model%0d credit", i), i == 0 ? int'(cr0) : int'(cr1), m_cr[i]);
            end
        end
        if (armed && pin_on) begin
            chk({pin_nm, " dispense"}, int'(disp[pin_sel]), int'(pin_e[3]));
            chk({pin_nm, " chg5"}, int'(chg[pin_sel]), int'(pin_e[2]));
            chk({pin_nm, " coin_reject"}, int'(rej[pin_sel]), int'(pin_e[1]));
            chk({pin_nm, " busy"}, int'(bsy[pin_sel]), int'(pin_e[0]));
            chk({pin_nm, " credit"}, pin_sel == 0 ? int'(cr0) : int'(cr1), pin_cr);
        end
    end

    always @(posedge clk) begin
        if (rst) armed <= 1'b1;
        m_cr <= n_cr;
        m_ow <= n_ow;
    end

    // pin e = {dispense, chg5, coin_reject, busy}; credit is the value visible during the cycle
    task automatic drive(input logic [1:0] c, input logic k = 1'b0, input logic r = 1'b0,
                         input string nm = "", input logic [3:0] e = 4'b0,
                         input int cv = 0, input int sel = 0);
        @(posedge clk);
        #1;
        coin = c; cancel = k; rst = r;
        pin_on = nm != ""; pin_nm = nm; pin_e = e; pin_cr = cv; pin_sel = sel;
        @(negedge clk);
    endtask

    initial begin
        drive(2'b00, 1'b0, 1'b1);
        drive(2'b01, 1'b0, 1'b0, "s1 c5a", 4'b0000, 0);
        drive(2'b01, 1'b0, 1'b0, "s1 c5b", 4'b0000, 5);
        drive(2'b10, 1'b0, 1'b0, "s1 c10", 4'b1000, 10);
        drive(2'b00, 1'b0, 1'b0, "s1 idle", 4'b0000, 0);
        drive(2'b10, 1'b0, 1'b0, "s2 c10a", 4'b0000, 0);
        drive(2'b10, 1'b0, 1'b0, "s2 c10b", 4'b1000, 10);
        drive(2'b01, 1'b0, 1'b0, "s2 c5", 4'b0000, 0);
        drive(2'b00, 1'b0, 1'b0, "s2 idle", 4'b0000, 5);
        drive(2'b00, 1'b1, 1'b0, "s2 refund", 4'b0100, 5);
        drive(2'b00, 1'b0, 1'b0, "s2 clear", 4'b0000, 0);
        drive(2'b01);
        drive(2'b10);
        drive(2'b11, 1'b0, 1'b0, "s3 c25", 4'b1100, 15);
        drive(2'b01, 1'b0, 1'b0, "s3 busy coin", 4'b0111, 0);
        drive(2'b00, 1'b0, 1'b0, "s3 pulse3", 4'b0101, 0);
        drive(2'b00, 1'b0, 1'b0, "s3 pulse4", 4'b0101, 0);
        drive(2'b00, 1'b0, 1'b0, "s3 done", 4'b0000, 0);
        drive(2'b01);
        drive(2'b10);
        drive(2'b00, 1'b1, 1'b0, "s4 cancel", 4'b0100, 15);
        drive(2'b00, 1'b0, 1'b0, "s4 pulse2", 4'b0101, 0);
        drive(2'b00, 1'b0, 1'b0, "s4 pulse3", 4'b0101, 0);
        drive(2'b00, 1'b0, 1'b0, "s4 done", 4'b0000, 0);
        drive(2'b00, 1'b1, 1'b0, "s4 cancel empty", 4'b0000, 0);
        drive(2'b01);
        drive(2'b10, 1'b1, 1'b0, "s5 cancel+coin", 4'b0110, 5);
        drive(2'b00, 1'b0, 1'b0, "s5 after", 4'b0000, 0);
        drive(2'b01);
        drive(2'b11, 1'b0, 1'b0, "s5 q25 off", 4'b0010, 5, 1);
        drive(2'b00, 1'b0, 1'b0, "s5 q25 off after", 4'b0000, 5, 1);
        drive(2'b00, 1'b1);
        drive(2'b00);
        drive(2'b00);
        drive(2'b01);
        drive(2'b10);
        drive(2'b11, 1'b0, 1'b0, "s6 c25", 4'b1100, 15);
        drive(2'b00, 1'b0, 1'b1, "s6 rst", 4'b0001, 0);
        drive(2'b00, 1'b0, 1'b0, "s6 after rst", 4'b0000, 0);
        drive(2'b10, 1'b0, 1'b0, "s6 c10a", 4'b0000, 0);
        drive(2'b10, 1'b0, 1'b0, "s6 c10b", 4'b1000, 10);
        drive(2'b00, 1'b0, 1'b0, "s6 idle", 4'b0000, 0);
        drive(2'b00);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/vending_mealy_param.md
Name: vending_mealy_param

Overview:
Parametrised successor to the single-price 5/10 vending FSM. It accepts 5/10/25-unit coins and dispenses in the same cycle that credit reaches PRICE (Mealy output). Change above a single nickel is paid out as a train of one-per-cycle chg5 pulses, and a cancel input refunds the accumulated credit the same way. It sits between the coin-acceptor decode and the dispense and change actuators.

Parameters:
PRICE, 20, item price in money units; must be a nonzero multiple of 5.
CREDIT_W, 6, width of internal credit and payout counters, counted in 5-unit steps; must hold PRICE/5+5.
EN_Q25, 1, 1 = coin code 2'b11 is a 25-unit coin; 0 = code 2'b11 is invalid and rejected.

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  synchronous active-high reset
coin  input  2  one-cycle coin strobe: 00 none, 01 = 5, 10 = 10, 11 = 25 (only if EN_Q25)
cancel  input  1  one-cycle request to refund current credit
dispense  output  1  Mealy; high for exactly the cycle in which the purchase completes
chg5  output  1  one 5-unit coin returned per cycle high
coin_reject  output  1  Mealy; high in the cycle a nonzero coin is not accepted
busy  output  1  registered; high while payout_cnt > 0
credit  output  CREDIT_W+3  registered current credit in money units (credit_u*5)

Behaviour:
- State
  - credit_u: credit in 5-unit steps.
  - payout_cnt: chg5 pulses still owed after the current cycle.
  - Logical states: ACCEPT when payout_cnt == 0; PAYOUT otherwise.
- Reset
  - While rst is high: dispense, chg5 and coin_reject are forced to 0, regardless of coin or cancel.
  - At the clock edge: credit_u <= 0 and payout_cnt <= 0, so busy = 0 and credit = 0 after the edge.
  - Reset mid-payout abandons the remaining pulses, with no chg5 in the reset cycle.
- Coin value v (in 5-unit steps)
  - 01 -> 1; 10 -> 2; 11 -> 5 if EN_Q25.
  - 11 with EN_Q25 = 0 -> v = 0, coin_reject = 1, no state change.
- ACCEPT, coin valid, cancel low
  - sum = credit_u + v.
  - If sum < PRICE/5: credit_u <= sum, all outputs low.
  - If sum >= PRICE/5: dispense = 1 in this cycle, credit_u <= 0, chg = sum - PRICE/5.
    - chg > 0: chg5 = 1 in this cycle and payout_cnt <= chg - 1.
    - chg == 0: chg5 = 0.
  - Latency: dispense and the first chg5 are combinational from the coin in the sampling cycle.
- ACCEPT, cancel high
  - Cancel has priority over a simultaneous coin; that coin is rejected (coin_reject = 1 if coin != 0).
  - If credit_u > 0: chg5 = 1 in this cycle, payout_cnt <= credit_u - 1, credit_u <= 0.
  - If credit_u == 0: no-op.
  - dispense stays 0.
- PAYOUT (payout_cnt > 0)
  - chg5 = 1 every cycle and payout_cnt decrements.
  - Any nonzero coin gets coin_reject = 1 and is not credited.
  - cancel is ignored and dispense stays 0.
  - Returns to ACCEPT on the edge where payout_cnt goes 1 -> 0.
  - busy is high exactly for the cycles after the first pulse.
- Pulse count: total chg5 pulses per event = chg (or refunded credit_u), contiguous, one per cycle.
- Bound: max change = (PRICE/5 - 1) + 5 - PRICE/5 = 4 pulses with EN_Q25; 1 pulse without it.
- Coin strobes are one cycle; a coin held high for N cycles counts as N coins.

Test Plan:
1. Reset, then coins 5, 5, 10 (PRICE = 20) -> dispense = 1 only in the cycle of the 10 coin; chg5 = 0; credit reads 5, 10, then 0.
2. Coins 10, 10, then 5 -> dispense on the second 10 with chg5 = 0; after the 5, credit = 5, busy = 0.
3. Coins 5, 10, then 25 -> dispense = 1 and chg5 = 1 in the 25 cycle; chg5 stays high 3 more cycles (4 total); busy high for those 3 cycles. A 5 coin inserted during busy -> coin_reject = 1, credit stays 0.
4. Credit 15, then cancel -> chg5 high for 3 consecutive cycles starting in the cancel cycle; dispense = 0; credit = 0. A cancel with credit = 0 -> no outputs.
5. Cancel and a 10 coin in the same cycle with credit 5 -> coin_reject = 1 and chg5 = 1 for 1 cycle; credit = 0. With EN_Q25 = 0, coin 11 -> coin_reject = 1 and credit unchanged.
6. rst asserted during the 2nd cycle of the 4-pulse payout from scenario 3 -> chg5 = 0 in the rst cycle and after it; busy = 0 and credit = 0 after the edge; a following 10, 10 dispenses normally.
